// File: rtl/prj_processor_pwm_pkg.sv
// Shared constants and helpers for the processor PWM generator.
package prj_processor_pwm_pkg;

    localparam int PWM_DUTY_W            = 8;
    localparam logic [PWM_DUTY_W-1:0] PWM_CNT_MAX = 8'd254;
    localparam int PWM_DEFAULT_PRESCALE  = 4;
    localparam int PWM_PRE_CNT_W         = 16;

    typedef logic [PWM_DUTY_W-1:0] pwm_duty_t;

    // Next value of the period counter on a step: 0..PWM_CNT_MAX, then wrap.
    function automatic pwm_duty_t pwm_next_cnt(input pwm_duty_t cnt);
        return (cnt == PWM_CNT_MAX) ? '0 : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/prj_processor_pwm_prescaler.sv
// Modulo-PRESCALE counter with enable and clear; step marks the last count.
module prj_processor_pwm_prescaler
    import prj_processor_pwm_pkg::*;
#(
    parameter int PRESCALE = PWM_DEFAULT_PRESCALE
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     clear,
    output logic                     step,
    output logic [PWM_PRE_CNT_W-1:0] count
);

    localparam logic [PWM_PRE_CNT_W-1:0] LAST = PWM_PRE_CNT_W'(PRESCALE - 1);

    logic [PWM_PRE_CNT_W-1:0] pre_cnt_q;
    logic [PWM_PRE_CNT_W-1:0] pre_cnt_d;

    // Count while enabled; disabled or cleared parks the counter at zero.
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (!enable || clear) begin
            pre_cnt_d = '0;
        end else if (pre_cnt_q == LAST) begin
            pre_cnt_d = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

    assign step  = enable && !clear && (pre_cnt_q == LAST);
    assign count = pre_cnt_q;

endmodule

// File: rtl/prj_processor_pwm_generator.sv
// PWM generator fed by the PIO duty port; duty changes apply at period wrap.
module prj_processor_pwm_generator
    import prj_processor_pwm_pkg::*;
#(
    parameter int PRESCALE = PWM_DEFAULT_PRESCALE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [PWM_DUTY_W-1:0] duty_in,
    input  logic                  enable,
    output logic                  pwm_out,
    output logic                  period_start,
    output logic [PWM_DUTY_W-1:0] duty_active
);

    logic                     step;
    logic [PWM_PRE_CNT_W-1:0] pre_cnt;

    pwm_duty_t cnt_q,  cnt_d;
    pwm_duty_t duty_q, duty_d;
    logic      pwm_q,  pwm_d;
    logic      start_q, start_d;

    prj_processor_pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .clear   (1'b0),
        .step    (step),
        .count   (pre_cnt)
    );

    // Period counter and shadow duty: idle tracks duty_in, running loads it at wrap.
    always_comb begin
        cnt_d  = cnt_q;
        duty_d = duty_q;
        if (!enable) begin
            cnt_d  = '0;
            duty_d = duty_in;
        end else if (step) begin
            cnt_d = pwm_next_cnt(cnt_q);
            if (cnt_q == PWM_CNT_MAX) begin
                duty_d = duty_in;
            end
        end
    end

    // Comparator and period marker, registered so the pin never sees comb glitches.
    always_comb begin
        pwm_d   = enable && (cnt_q < duty_q);
        start_d = enable && (cnt_q == '0) && (pre_cnt == '0);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            duty_q  <= '0;
            pwm_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            pwm_q   <= pwm_d;
            start_q <= start_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = start_q;
    assign duty_active  = duty_q;

endmodule

// File: tb/tb_prj_processor_pwm_generator.sv
// Directed bench: one instance at PRESCALE=1, one at PRESCALE=4.
module tb_prj_processor_pwm_generator;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] duty1, duty4;
    logic       en1, en4;
    logic       pwm1, pwm4, ps1, ps4;
    logic [7:0] dact1, dact4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prj_processor_pwm_generator #(.PRESCALE(1)) dut1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .duty_in      (duty1),
        .enable       (en1),
        .pwm_out      (pwm1),
        .period_start (ps1),
        .duty_active  (dact1)
    );

    prj_processor_pwm_generator #(.PRESCALE(4)) dut4 (
        .clk          (clk),
        .reset_n      (reset_n),
        .duty_in      (duty4),
        .enable       (en4),
        .pwm_out      (pwm4),
        .period_start (ps4),
        .duty_active  (dact4)
    );

    typedef struct {
        logic [7:0] duty;
        int         exp_high;   // high samples over 3 periods
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end else begin
            $display("ok   %s: %0d", name, actual);
        end
    endtask

    task automatic step1();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Run n samples on dut4 from a fresh enable, returning high count and
    // the number of samples where period_start disagreed with the 1020-clk grid.
    task automatic run4(input int n, output int highs, output int ps_err);
        highs  = 0;
        ps_err = 0;
        for (int k = 1; k <= n; k++) begin
            step1();
            highs += int'(pwm4);
            if (ps4 != (((k - 1) % 1020) == 0)) ps_err++;
        end
    endtask

    initial begin
        int highs, ps_err, high_a, high_b;

        vecs[0] = '{duty: 8'd128, exp_high: 3 * 128};
        vecs[1] = '{duty: 8'd0,   exp_high: 0};
        vecs[2] = '{duty: 8'd255, exp_high: 3 * 255};
        vecs[3] = '{duty: 8'd1,   exp_high: 3};
        vecs[4] = '{duty: 8'd254, exp_high: 3 * 254};

        reset_n = 1'b0;
        duty1 = 8'd0; duty4 = 8'd0;
        en1 = 1'b0;   en4 = 1'b0;
        #3;
        check("reset pwm1", int'(pwm1), 0);
        check("reset ps1", int'(ps1), 0);
        check("reset dact1", int'(dact1), 0);
        check("reset pwm4", int'(pwm4), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Table: PRESCALE=1, three periods per duty value
        for (int i = 0; i < 5; i++) begin
            en1   = 1'b0;
            duty1 = vecs[i].duty;
            step1();
            check($sformatf("v%0d idle load dact", i), int'(dact1), int'(vecs[i].duty));
            en1    = 1'b1;
            highs  = 0;
            ps_err = 0;
            for (int k = 1; k <= 765; k++) begin
                step1();
                if (k == 1) begin
                    check($sformatf("v%0d first ps", i), int'(ps1), 1);
                    check($sformatf("v%0d first pwm", i), int'(pwm1), (vecs[i].duty != 0) ? 1 : 0);
                end
                highs += int'(pwm1);
                if (ps1 != (((k - 1) % 255) == 0)) ps_err++;
            end
            check($sformatf("v%0d high count", i), highs, vecs[i].exp_high);
            check($sformatf("v%0d ps grid err", i), ps_err, 0);
            en1 = 1'b0;
        end

        // PRESCALE=4: duty 64 -> 192 written mid-period at cnt=100
        en4 = 1'b0; duty4 = 8'd64;
        step1();
        en4 = 1'b1;
        high_a = 0; high_b = 0;
        for (int k = 1; k <= 2040; k++) begin
            step1();
            if (k <= 1020) high_a += int'(pwm4);
            else           high_b += int'(pwm4);
            if (k == 401)  duty4 = 8'd192;
            if (k == 1019) check("shadow before wrap", int'(dact4), 64);
            if (k == 1020) check("shadow at wrap", int'(dact4), 192);
        end
        check("period 64 high clk", high_a, 256);
        check("period 192 high clk", high_b, 768);

        // Drop enable at cnt=50, change duty while idle, re-enable
        en4 = 1'b0; duty4 = 8'd200;
        step1();
        en4 = 1'b1;
        for (int k = 1; k <= 201; k++) step1();
        check("pre-drop pwm high", int'(pwm4), 1);
        en4 = 1'b0; duty4 = 8'd37;
        step1();
        check("drop pwm", int'(pwm4), 0);
        check("drop cnt", int'(dut4.cnt_q), 0);
        check("drop ps", int'(ps4), 0);
        check("idle duty load", int'(dact4), 37);
        en4 = 1'b1;
        step1();
        check("reenable ps", int'(ps4), 1);
        check("reenable pwm", int'(pwm4), 1);
        highs = 1;
        ps_err = 0;
        for (int k = 2; k <= 1020; k++) begin
            step1();
            highs += int'(pwm4);
            if (ps4 != 1'b0) ps_err++;
        end
        check("reenable high clk", highs, 37 * 4);
        check("reenable ps extra", ps_err, 0);
        run4(1020, highs, ps_err);
        check("second period high clk", highs, 37 * 4);
        check("second period ps grid", ps_err, 0);

        // Asynchronous reset mid-period with pwm high
        en4 = 1'b0; duty4 = 8'd200;
        step1();
        en4 = 1'b1;
        for (int k = 1; k <= 10; k++) step1();
        check("pre-reset pwm", int'(pwm4), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async rst pwm", int'(pwm4), 0);
        check("async rst ps", int'(ps4), 0);
        check("async rst dact", int'(dact4), 0);
        duty4 = 8'd10; en4 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step1();
        check("post-reset idle load", int'(dact4), 10);
        en4 = 1'b1;
        run4(1020, highs, ps_err);
        check("post-reset high clk", highs, 40);
        check("post-reset ps grid", ps_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
